seq_mult_unit: RTL and testbench

//   Iterative shift-add unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/mult_pkg.sv | 13 +
 rtl/seq_mult_dp.sv | 57 +++++
 rtl/seq_mult_unit.sv | 102 ++++++++++
 tb/tb_seq_mult_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encodings and default width.
package mult_pkg;

   localparam int unsigned DefaultWidth = 10;

   // 2'd3 is unused and recovers to StIdle.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/seq_mult_dp.sv
// Shift-add datapath: multiplicand/multiplier shift registers and the 2*WIDTH accumulator.
module seq_mult_dp
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               clear_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] acc_sum_o
);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_sum;

   // Sum including the current partial product; the FSM captures this on the last step.
   assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign acc_sum_o = acc_sum;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (clear_i) begin
         mcand_d  = '0;
         mplier_d = '0;
         acc_d    = '0;
      end else if (load_i) begin
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         acc_d    = '0;
      end else if (step_i) begin
         acc_d    = acc_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

endmodule

// File: rtl/seq_mult_unit.sv
// Iterative unsigned WIDTH x WIDTH multiplier with go/done handshake and fixed WIDTH-cycle latency.
module seq_mult_unit
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               go,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e             state_q;
   logic [CntW-1:0]    count_q;
   logic               busy_q;
   logic               done_q;
   logic [2*WIDTH-1:0] product_q;

   logic               accept;
   logic               dp_load;
   logic               dp_step;
   logic               dp_clear;
   logic [2*WIDTH-1:0] acc_sum;

   // go is honoured only when no operation is in flight.
   assign accept   = go && ((state_q == StIdle) || (state_q == StDone));
   assign dp_load  = accept;
   assign dp_step  = (state_q == StBusy);
   assign dp_clear = !accept && (state_q != StIdle) && (state_q != StBusy);

   seq_mult_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk       (clk),
      .rst       (rst),
      .load_i    (dp_load),
      .step_i    (dp_step),
      .clear_i   (dp_clear),
      .a_i       (a),
      .b_i       (b),
      .acc_sum_o (acc_sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (go) begin
                  state_q <= StBusy;
                  count_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StBusy: begin
               count_q <= count_q + 1'b1;
               if (count_q == LastCnt) begin
                  product_q <= acc_sum;
                  state_q   <= StDone;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end
            end
            StDone: begin
               done_q <= 1'b0;
               if (go) begin
                  state_q <= StBusy;
                  count_q <= '0;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= StIdle;
                  count_q <= '0;
               end
            end
            default: begin
               state_q <= StIdle;
               count_q <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed self-checking bench for seq_mult_unit with hand-computed products and latencies.
module tb_seq_mult_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [9:0]  a;
   logic [9:0]  b;
   logic        busy;
   logic        done;
   logic [19:0] product;

   int checks = 0;
   int errors = 0;

   seq_mult_unit #(
      .WIDTH (10)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .go      (go),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Launch one operation and follow it to done; optionally re-pulse go mid-BUSY.
   task automatic run_op(input logic [9:0] av, input logic [9:0] bv, input logic [19:0] exp,
                         input int repulse, input string tag);
      int          lat;
      int          busy_cnt;
      logic [19:0] prev;
      logic        stable;
      @(negedge clk);
      a    = av;
      b    = bv;
      go   = 1'b1;
      prev = product;
      @(negedge clk);
      go       = 1'b0;
      lat      = 0;
      busy_cnt = 0;
      stable   = 1'b1;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         if (product !== prev) stable = 1'b0;
         if (lat == repulse) begin
            go = 1'b1;
            a  = 10'd9;
            b  = 10'd9;
         end else begin
            go = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      go = 1'b0;
      check_eq({tag, " latency"}, lat, 10);
      check_eq({tag, " busy cycles"}, busy_cnt, 10);
      check_eq({tag, " product"}, product, exp);
      check_eq({tag, " busy low at done"}, busy, 0);
      check_eq({tag, " product stable while busy"}, stable, 1);
      @(negedge clk);
      check_eq({tag, " done one cycle"}, done, 0);
      check_eq({tag, " product held"}, product, exp);
   endtask

   initial begin
      int lat;
      int pulses;
      rst = 1'b1;
      go  = 1'b0;
      a   = '0;
      b   = '0;
      repeat (2) @(negedge clk);
      check_eq("reset busy", busy, 0);
      check_eq("reset done", done, 0);
      check_eq("reset product", product, 0);
      rst = 1'b0;

      run_op(10'd3, 10'd5, 20'd15, -1, "3x5");
      run_op(10'd1023, 10'd1023, 20'hFF801, -1, "1023x1023");
      run_op(10'd0, 10'd777, 20'd0, -1, "0x777");
      run_op(10'd777, 10'd0, 20'd0, -1, "777x0");
      run_op(10'd512, 10'd2, 20'd1024, -1, "512x2");
      run_op(10'd3, 10'd5, 20'd15, 4, "repulse ignored");

      // Back-to-back: go held through DONE with new operands.
      @(negedge clk);
      a  = 10'd3;
      b  = 10'd5;
      go = 1'b1;
      @(negedge clk);
      a   = 10'd6;
      b   = 10'd7;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_eq("b2b first latency", lat, 10);
      check_eq("b2b first product", product, 15);
      @(negedge clk);
      go = 1'b0;
      check_eq("b2b no idle bubble", busy, 1);
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_eq("b2b second latency", lat, 10);
      check_eq("b2b second product", product, 42);
      @(negedge clk);

      // Asynchronous reset during BUSY.
      a  = 10'd100;
      b  = 10'd100;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("pre-reset busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("async reset busy", busy, 0);
      check_eq("async reset done", done, 0);
      check_eq("async reset product", product, 0);
      @(negedge clk);
      rst    = 1'b0;
      pulses = 0;
      repeat (15) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      check_eq("no activity after abort", pulses, 0);
      check_eq("product zero after abort", product, 0);
      run_op(10'd3, 10'd5, 20'd15, -1, "after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
